// File: rtl/mem_access_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage, grouped as one bus.
// The master side is the pipeline around the stage; the slave side is the stage itself.
interface mem_access_stage_if #(
    parameter int unsigned NB_PC   = 32,
    parameter int unsigned NB_REG  = 5,
    parameter int unsigned NB_DATA = 32
);
    logic               MEM_reg_write;
    logic               MEM_mem_to_reg;
    logic               MEM_mem_read;
    logic               MEM_mem_write;
    logic               MEM_branch;
    logic               MEM_zero;
    logic [NB_PC-1:0]   MEM_branch_address;
    logic [NB_DATA-1:0] MEM_alu_result;
    logic [NB_DATA-1:0] MEM_store_data;
    logic [1:0]         MEM_size;
    logic               MEM_unsigned;
    logic [NB_REG-1:0]  MEM_selected_reg;

    logic               WB_reg_write;
    logic               WB_mem_to_reg;
    logic [NB_DATA-1:0] WB_read_data;
    logic [NB_DATA-1:0] WB_alu_result;
    logic [NB_REG-1:0]  WB_selected_reg;

    modport master (
        output MEM_reg_write, MEM_mem_to_reg, MEM_mem_read, MEM_mem_write, MEM_branch,
               MEM_zero, MEM_branch_address, MEM_alu_result, MEM_store_data, MEM_size,
               MEM_unsigned, MEM_selected_reg,
        input  WB_reg_write, WB_mem_to_reg, WB_read_data, WB_alu_result, WB_selected_reg
    );

    modport slave (
        input  MEM_reg_write, MEM_mem_to_reg, MEM_mem_read, MEM_mem_write, MEM_branch,
               MEM_zero, MEM_branch_address, MEM_alu_result, MEM_store_data, MEM_size,
               MEM_unsigned, MEM_selected_reg,
        output WB_reg_write, WB_mem_to_reg, WB_read_data, WB_alu_result, WB_selected_reg
    );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: branch resolve, data RAM with read-modify-write sub-word stores.
// Define MEM_ALIGN_CHECK_EN to suppress misaligned accesses and expose o_misaligned.
module mem_access_stage #(
    parameter int unsigned NB_PC   = 32,
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    mem_access_stage_if.slave bus,
    output logic             o_pc_src,
    output logic [NB_PC-1:0] o_branch_address,
`ifdef MEM_ALIGN_CHECK_EN
    output logic             o_misaligned,
`endif
    output logic             o_stall
);
    localparam int unsigned Depth = 2 ** NB_ADDR;
    localparam logic [NB_DATA-1:0] ByteMask = NB_DATA'(8'hFF);
    localparam logic [NB_DATA-1:0] HalfMask = NB_DATA'(16'hFFFF);

    typedef enum logic [0:0] {StIdle, StMerge} state_e;

    state_e             state_q, state_d;
    logic [NB_DATA-1:0] ram_q [Depth];
    logic [NB_DATA-1:0] rdata_q;
    logic [NB_ADDR-1:0] word_addr;
    logic [1:0]         offset;
    logic               is_load, is_store, is_sub, misaligned, access_ok;
    logic               ram_we, bubble;
    logic [NB_DATA-1:0] ram_wdata, lane_mask, lane_data, merged;
    logic               load_q, unsigned_q;
    logic [1:0]         offset_q, size_q;
    logic [NB_DATA-1:0] byte_shift, half_shift, read_data;

    assign o_pc_src         = bus.MEM_branch & bus.MEM_zero;
    assign o_branch_address = bus.MEM_branch_address;

    assign word_addr = bus.MEM_alu_result[NB_ADDR+1:2];
    assign offset    = bus.MEM_alu_result[1:0];
    assign is_store  = bus.MEM_mem_write;
    assign is_load   = bus.MEM_mem_read & ~bus.MEM_mem_write;
    assign is_sub    = ~bus.MEM_size[1];

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (bus.MEM_mem_read | bus.MEM_mem_write) &
                        (((bus.MEM_size == 2'b01) & offset[0]) |
                         (bus.MEM_size[1] & (offset != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif
    assign access_ok = ~misaligned;

    always_comb begin
        lane_mask = '0;
        lane_data = '0;
        if (bus.MEM_size == 2'b00) begin
            lane_mask = ByteMask << {offset, 3'b000};
            lane_data = {(NB_DATA / 8){bus.MEM_store_data[7:0]}};
        end else begin
            lane_mask = HalfMask << {offset[1], 4'b0000};
            lane_data = {(NB_DATA / 16){bus.MEM_store_data[15:0]}};
        end
        merged = (rdata_q & ~lane_mask) | (lane_data & lane_mask);
    end

    // Inputs are held by upstream during the stall, so MERGE re-decodes the same store.
    always_comb begin
        state_d   = state_q;
        o_stall   = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = bus.MEM_store_data;
        bubble    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (is_store && access_ok) begin
                    if (is_sub) begin
                        o_stall = 1'b1;
                        bubble  = 1'b1;
                        state_d = StMerge;
                    end else begin
                        ram_we = 1'b1;
                    end
                end
            end
            StMerge: begin
                ram_we    = 1'b1;
                ram_wdata = merged;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (i_reset) begin
            ram_we  = 1'b0;
            o_stall = 1'b0;
        end
    end

    // Read-first single-port RAM; the word is read every cycle.
    always_ff @(posedge i_clock) begin
        if (ram_we) ram_q[word_addr] <= ram_wdata;
        rdata_q <= ram_q[word_addr];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q             <= StIdle;
            bus.WB_reg_write    <= 1'b0;
            bus.WB_mem_to_reg   <= 1'b0;
            bus.WB_alu_result   <= '0;
            bus.WB_selected_reg <= '0;
            load_q              <= 1'b0;
            unsigned_q          <= 1'b0;
            offset_q            <= 2'b00;
            size_q              <= 2'b00;
        end else begin
            state_q             <= state_d;
            bus.WB_reg_write    <= bus.MEM_reg_write & ~bubble & access_ok;
            bus.WB_mem_to_reg   <= bus.MEM_mem_to_reg & ~bubble;
            bus.WB_alu_result   <= bus.MEM_alu_result;
            bus.WB_selected_reg <= bus.MEM_selected_reg;
            load_q              <= is_load & access_ok;
            unsigned_q          <= bus.MEM_unsigned;
            offset_q            <= offset;
            size_q              <= bus.MEM_size;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge i_clock) begin
        if (i_reset) o_misaligned <= 1'b0;
        else         o_misaligned <= misaligned;
    end
`endif

    always_comb begin
        byte_shift = rdata_q >> {offset_q, 3'b000};
        half_shift = rdata_q >> {offset_q[1], 4'b0000};
        unique case (size_q)
            2'b00:   read_data = {{(NB_DATA - 8){byte_shift[7] & ~unsigned_q}}, byte_shift[7:0]};
            2'b01:   read_data = {{(NB_DATA - 16){half_shift[15] & ~unsigned_q}},
                                  half_shift[15:0]};
            default: read_data = rdata_q;
        endcase
        if (!load_q) read_data = '0;
    end

    assign bus.WB_read_data = read_data;
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the five-stage pipeline: consumes the EX/MEM pipeline register outputs, resolves the branch decision, performs data-memory loads and stores, and drives the MEM/WB register. It owns a single-port synchronous data RAM. Byte and halfword stores are done as read-modify-write, which stalls the front of the pipeline for one cycle. Load data is extracted, extended, and delivered aligned with the MEM/WB register.

## Interface
- NB_PC, 32, PC / branch address width
- NB_REG, 5, register-file index width
- NB_DATA, 32, data word width
- NB_ADDR, 8, data RAM word-address bits (2^NB_ADDR words)

- i_clock  in  1  clock; all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- MEM_reg_write, MEM_mem_to_reg, MEM_mem_read, MEM_mem_write, MEM_branch, MEM_zero  in  1 each  control and flag bits from EX/MEM
- MEM_branch_address  in  NB_PC  branch target
- MEM_alu_result  in  NB_DATA  byte address for memory ops; result otherwise
- MEM_store_data  in  NB_DATA  rt value to store
- MEM_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- MEM_unsigned  in  1  zero-extend loads when 1, sign-extend when 0
- MEM_selected_reg  in  NB_REG  destination register
- o_pc_src  out  1  MEM_branch & MEM_zero, combinational
- o_branch_address  out  NB_PC  MEM_branch_address passthrough
- o_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle
- WB_reg_write, WB_mem_to_reg  out  1 each  registered controls
- WB_read_data  out  NB_DATA  extracted load data
- WB_alu_result  out  NB_DATA  registered ALU result
- WB_selected_reg  out  NB_REG  registered destination
- o_misaligned  out  1  only with MEM_ALIGN_CHECK_EN

## Operation
- Addressing: word index = MEM_alu_result[NB_ADDR+1:2]; offset = [1:0]; little-endian byte lanes.
- MEM_mem_write has priority if both read and write are asserted; the access is handled as a store.
- Word store: written in the same cycle; no stall.
- Sub-word store: FSM IDLE -> MERGE -> IDLE.
  - IDLE with a byte or half store: o_stall=1 (combinational); RAM read of the word issued; MEM/WB loads a bubble (WB_reg_write=0, WB_mem_to_reg=0).
  - MERGE: o_stall=0; the store lane(s) are replaced in the read word and the word is written; MEM/WB captures the instruction normally.
  - Upstream holds EX/MEM during the stall, so inputs are stable across both cycles.
- Load: RAM read issued in the MEM cycle. Offset, size and unsigned are registered alongside, and extraction/extension is applied on the RAM output. WB_read_data is valid during the WB cycle.
  - Byte uses lane offset; half uses lane offset[1].
- Non-memory instructions pass controls and ALU result to MEM/WB.
- When neither memory strobe is set, WB_read_data is 0.

## Timing
- Reset values:
  - WB_reg_write, WB_mem_to_reg, WB_read_data, WB_alu_result, WB_selected_reg, and registered offset/size all 0.
  - FSM in IDLE; o_stall=0; o_misaligned=0.
  - RAM contents are not reset.
- Reset during MERGE aborts the store: no RAM write occurs and the FSM returns to IDLE.
- Latency: one cycle from MEM inputs to WB outputs; two cycles for sub-word stores.
- o_pc_src and o_branch_address have zero latency and are unaffected by the FSM.
- Load immediately after a store to the same word: returns the new data. The store completed in an earlier cycle, since the RAM is read-first only within the same cycle.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A half access with offset[0]=1, or a word access with offset≠0, is suppressed: no write, no RMW stall, WB_read_data=0, WB_reg_write forced 0.
  - o_misaligned is a registered one-cycle pulse aligned with WB.
- Not defined:
  - Low address bits that are illegal for the size are ignored (word uses the word index; half uses offset[1]).
  - The o_misaligned port is absent.

## Test plan
- Store word 0xDEADBEEF at addr 0x10, then load word at 0x10 -> WB_read_data=0xDEADBEEF one cycle after the load's MEM cycle; o_stall never asserted.
- With 0xDEADBEEF at 0x10, store byte 0x55 at 0x11 -> o_stall=1 for exactly one cycle and a bubble in WB; a following load word at 0x10 returns 0xDEAD55EF.
- Load byte at 0x13 with signed extension -> 0xFFFFFFDE; with MEM_unsigned=1 -> 0x000000DE; load half at 0x12 signed -> 0xFFFFDEAD.
- MEM_branch=1, MEM_zero=1, MEM_branch_address=0x40 -> o_pc_src=1 and o_branch_address=0x40 in the same cycle; with MEM_zero=0 -> o_pc_src=0.
- Assert i_reset in the MERGE cycle of a byte store to 0x20 -> word at 0x20 unchanged, all WB outputs 0, o_stall=0 in the next cycle.
- MEM_ALIGN_CHECK_EN: store word at 0x12 -> RAM unchanged and o_misaligned=1 for one cycle; without the macro -> the word at 0x10 is written.
